// File: rtl/to_rec_fn_if.sv
// ---------------------------------------------------------------------------
// to_rec_fn_if
// Operand/result bundle for the binary32 -> recoded-format converter.
//
//   in_valid      producer -> converter   fp is valid this cycle
//   fp            producer -> converter   binary32 operand {s, e[7:0], f[22:0]}
//   out_valid     converter -> consumer   registered outputs carry a new result
//   sign          converter -> consumer   copy of fp[31]
//   exp           converter -> consumer   recoded exponent (true exponent + 256)
//   sig           converter -> consumer   significand {hidden, fraction}
//   isNAN .. isUnormalize                 one-hot input class flags
//
// master : the operand producer (drives in_valid/fp, observes results)
// slave  : the converter itself
// ---------------------------------------------------------------------------
interface to_rec_fn_if;
    logic        in_valid;
    logic [31:0] fp;
    logic        out_valid;
    logic        sign;
    logic [8:0]  exp;
    logic [23:0] sig;
    logic        isNAN;
    logic        isINf;
    logic        isZero;
    logic        isNormalize;
    logic        isUnormalize;

    modport master (
        output in_valid,
        output fp,
        input  out_valid,
        input  sign,
        input  exp,
        input  sig,
        input  isNAN,
        input  isINf,
        input  isZero,
        input  isNormalize,
        input  isUnormalize
    );

    modport slave (
        input  in_valid,
        input  fp,
        output out_valid,
        output sign,
        output exp,
        output sig,
        output isNAN,
        output isINf,
        output isZero,
        output isNormalize,
        output isUnormalize
    );
endinterface

// File: rtl/to_rec_fn.sv
// ---------------------------------------------------------------------------
// to_rec_fn
// Converts an IEEE-754 binary32 operand into the FPU's internal recoded form:
// sign, 9-bit exponent biased so that exp = true exponent + 256, a 24-bit
// significand with the hidden bit made explicit, and one-hot class flags.
// Subnormals are normalised so downstream units always see 1.f.
// One registered stage, latency 1, no backpressure.
//
// Ports
//   clk   in   system clock
//   rst   in   synchronous active-high reset; wins over bus.in_valid
//   bus   to_rec_fn_if.slave
//         in_valid/fp in; out_valid, sign, exp, sig and class flags out
//
// Configuration
//   TORECFN_DAZ_EN  defined: denormals-are-zero. Subnormals produce exp=0,
//                   sig=0 with sign kept and isUnormalize still set; the
//                   leading-zero counter and shifter are not built.
//                   undefined (default): subnormals are normalised.
//
// Encoding summary (exp / sig)
//   zero       0x000 / 0x000000
//   subnormal  129-lz / {1, f << (lz+1)}
//   normal     e+129 / {1, f}
//   inf        0x180 / 0x800000
//   nan        0x1C0 / {1, f}
// ---------------------------------------------------------------------------
module to_rec_fn (
    input  logic             clk,
    input  logic             rst,
    to_rec_fn_if.slave       bus
);

    localparam logic [8:0]  EXP_NORM_OFS = 9'd129;
    localparam logic [8:0]  EXP_INF      = 9'h180;
    localparam logic [8:0]  EXP_NAN      = 9'h1C0;
    localparam logic [23:0] SIG_INF      = 24'h80_0000;

    // -----------------------------------------------------------------------
    // Field split and classification
    // -----------------------------------------------------------------------
    logic        w_s;
    logic [7:0]  w_e;
    logic [22:0] w_f;
    logic        w_e_max;
    logic        w_e_zero;
    logic        w_f_zero;
    logic        w_is_nan;
    logic        w_is_inf;
    logic        w_is_zero;
    logic        w_is_norm;
    logic        w_is_sub;

    assign w_s      = bus.fp[31];
    assign w_e      = bus.fp[30:23];
    assign w_f      = bus.fp[22:0];

    assign w_e_max  = &w_e;
    assign w_e_zero = ~|w_e;
    assign w_f_zero = ~|w_f;

    assign w_is_nan  = w_e_max  & ~w_f_zero;
    assign w_is_inf  = w_e_max  &  w_f_zero;
    assign w_is_zero = w_e_zero &  w_f_zero;
    assign w_is_sub  = w_e_zero & ~w_f_zero;
    assign w_is_norm = ~w_e_max & ~w_e_zero;

    // -----------------------------------------------------------------------
    // Subnormal handling
    // -----------------------------------------------------------------------
    logic [8:0]  w_sub_exp;
    logic [22:0] w_sub_frac;

`ifdef TORECFN_DAZ_EN
    // Denormals flush to zero magnitude; no normalisation hardware needed.
    assign w_sub_exp  = 9'd0;
    assign w_sub_frac = 23'd0;
`else
    logic [4:0]  w_lz;
    logic [22:0] w_sh;

    // Priority encoder: ascending scan so the highest set bit wins.
    // Result is only meaningful for f != 0, which is the only case it is used.
    always_comb begin
        w_lz = 5'd0;
        for (int i = 0; i < 23; i++) begin
            if (w_f[i]) begin
                w_lz = 5'(22 - i);
            end
        end
    end

    // Barrel shifter: the fixed extra shift by 1 pushes the leading one out
    // into the (implicit) hidden position; the remaining lz shift is done in
    // log2 stages.
    always_comb begin
        w_sh = {w_f[21:0], 1'b0};
        for (int k = 0; k < 5; k++) begin
            if (w_lz[k]) begin
                w_sh = w_sh << (1 << k);
            end
        end
    end

    assign w_sub_exp  = EXP_NORM_OFS - {4'd0, w_lz};
    assign w_sub_frac = w_sh;
`endif

    // -----------------------------------------------------------------------
    // Next-result mux
    // -----------------------------------------------------------------------
    logic [8:0]  w_nxt_exp;
    logic [23:0] w_nxt_sig;

    always_comb begin
        w_nxt_exp = 9'd0;
        w_nxt_sig = 24'd0;
        if (w_is_nan) begin
            // Payload and quiet bit pass through untouched.
            w_nxt_exp = EXP_NAN;
            w_nxt_sig = {1'b1, w_f};
        end else if (w_is_inf) begin
            w_nxt_exp = EXP_INF;
            w_nxt_sig = SIG_INF;
        end else if (w_is_zero) begin
            w_nxt_exp = 9'd0;
            w_nxt_sig = 24'd0;
        end else if (w_is_sub) begin
            w_nxt_exp = w_sub_exp;
`ifdef TORECFN_DAZ_EN
            w_nxt_sig = 24'd0;
`else
            w_nxt_sig = {1'b1, w_sub_frac};
`endif
        end else begin
            w_nxt_exp = {1'b0, w_e} + EXP_NORM_OFS;
            w_nxt_sig = {1'b1, w_f};
        end
    end

    // -----------------------------------------------------------------------
    // Output register
    // -----------------------------------------------------------------------
    logic        r_out_valid;
    logic        r_sign;
    logic [8:0]  r_exp;
    logic [23:0] r_sig;
    logic        r_is_nan;
    logic        r_is_inf;
    logic        r_is_zero;
    logic        r_is_norm;
    logic        r_is_sub;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sign      <= 1'b0;
            r_exp       <= 9'd0;
            r_sig       <= 24'd0;
            r_is_nan    <= 1'b0;
            r_is_inf    <= 1'b0;
            r_is_zero   <= 1'b0;
            r_is_norm   <= 1'b0;
            r_is_sub    <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            // Data and flags hold while idle so the last result stays visible.
            if (bus.in_valid) begin
                r_sign    <= w_s;
                r_exp     <= w_nxt_exp;
                r_sig     <= w_nxt_sig;
                r_is_nan  <= w_is_nan;
                r_is_inf  <= w_is_inf;
                r_is_zero <= w_is_zero;
                r_is_norm <= w_is_norm;
                r_is_sub  <= w_is_sub;
            end
        end
    end

    assign bus.out_valid    = r_out_valid;
    assign bus.sign         = r_sign;
    assign bus.exp          = r_exp;
    assign bus.sig          = r_sig;
    assign bus.isNAN        = r_is_nan;
    assign bus.isINf        = r_is_inf;
    assign bus.isZero       = r_is_zero;
    assign bus.isNormalize  = r_is_norm;
    assign bus.isUnormalize = r_is_sub;

endmodule

// File: tb/tb_to_rec_fn.sv
// ---------------------------------------------------------------------------
// tb_to_rec_fn
// Directed bench for to_rec_fn. A value-level model (true exponent + 256,
// normalise by locating the most significant set bit) predicts the result
// register every cycle; a set of literal expectations pins the model.
// Honours TORECFN_DAZ_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_to_rec_fn;

    localparam logic [4:0] C_NAN  = 5'b10000;
    localparam logic [4:0] C_INF  = 5'b01000;
    localparam logic [4:0] C_ZERO = 5'b00100;
    localparam logic [4:0] C_NORM = 5'b00010;
    localparam logic [4:0] C_SUB  = 5'b00001;

    typedef struct packed {
        logic        v;
        logic        s;
        logic [8:0]  e;
        logic [23:0] m;
        logic [4:0]  c;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    to_rec_fn_if bus ();

    to_rec_fn dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic  chk_on  = 1'b0;
    logic  lit_en  = 1'b0;
    res_t  lit_want;
    string lit_name;

    function automatic res_t mk(input logic v, input logic s, input logic [8:0] e,
                                input logic [23:0] m, input logic [4:0] c);
        res_t r;
        r.v = v; r.s = s; r.e = e; r.m = m; r.c = c;
        return r;
    endfunction

    // Value-level model of the conversion.
    function automatic res_t model(input logic [31:0] x);
        res_t        r;
        int          ex;
        int          p;
        logic [22:0] f;
        longint      t;
        ex = int'(x[30:23]);
        f  = x[22:0];
        r  = '0;
        r.v = 1'b1;
        r.s = x[31];
        if (ex == 255 && f != 0) begin
            r.c = C_NAN;  r.e = 9'h1C0; r.m = {1'b1, f};
        end else if (ex == 255) begin
            r.c = C_INF;  r.e = 9'h180; r.m = 24'h800000;
        end else if (ex == 0 && f == 0) begin
            r.c = C_ZERO; r.e = 9'h000; r.m = 24'h000000;
        end else if (ex == 0) begin
            r.c = C_SUB;
`ifdef TORECFN_DAZ_EN
            r.e = 9'h000; r.m = 24'h000000;
`else
            // value = f * 2^-149; msb at position p gives true exponent p-149
            p = 0;
            for (int i = 0; i < 23; i++) if (f[i]) p = i;
            r.e = 9'(p - 149 + 256);
            t   = longint'(f) << (23 - p);
            r.m = t[23:0];
`endif
        end else begin
            r.c = C_NORM;
            r.e = 9'(ex - 127 + 256);
            r.m = {1'b1, f};
        end
        return r;
    endfunction

    res_t m_q;
    res_t got;

    always @(posedge clk) begin
        if (rst)               m_q <= '0;
        else if (bus.in_valid) m_q <= model(bus.fp);
        else                   m_q.v <= 1'b0;
    end

    assign got = {bus.out_valid, bus.sign, bus.exp, bus.sig,
                  bus.isNAN, bus.isINf, bus.isZero, bus.isNormalize, bus.isUnormalize};

    always @(negedge clk) begin
        if (chk_on) begin
            total++;
            if (got !== m_q) begin
                bad++;
                $display("FAIL model t=%0t got=%h want=%h", $time, got, m_q);
            end
            if (lit_en) begin
                total++;
                if (got !== lit_want) begin
                    bad++;
                    $display("FAIL %s got=%h want=%h", lit_name, got, lit_want);
                end
            end
        end
    end

    task automatic step(input logic [31:0] f, input logic v);
        bus.fp       = f;
        bus.in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input res_t w);
        lit_name = nm;
        lit_want = w;
        lit_en   = 1'b1;
        @(negedge clk);
        #1;
        lit_en   = 1'b0;
    endtask

    initial begin
        bus.fp       = 32'h0;
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        step(32'h3F80_0000, 1'b1);
        chk_on = 1'b1;
        lit("reset", '0);
        rst = 1'b0;

        step(32'hFF80_0000, 1'b1); lit("neg_inf",  mk(1, 1, 9'h180, 24'h800000, C_INF));
        step(32'h3F80_0000, 1'b1); lit("one",      mk(1, 0, 9'h100, 24'h800000, C_NORM));
        step(32'h7F7F_FFFF, 1'b1); lit("max_norm", mk(1, 0, 9'h17F, 24'hFFFFFF, C_NORM));
`ifdef TORECFN_DAZ_EN
        step(32'h0000_0001, 1'b1); lit("min_sub",  mk(1, 0, 9'h000, 24'h000000, C_SUB));
        step(32'h0040_0000, 1'b1); lit("half_sub", mk(1, 0, 9'h000, 24'h000000, C_SUB));
        step(32'h007F_FFFF, 1'b1); lit("max_sub",  mk(1, 0, 9'h000, 24'h000000, C_SUB));
`else
        step(32'h0000_0001, 1'b1); lit("min_sub",  mk(1, 0, 9'h06B, 24'h800000, C_SUB));
        step(32'h0040_0000, 1'b1); lit("half_sub", mk(1, 0, 9'h081, 24'h800000, C_SUB));
        step(32'h007F_FFFF, 1'b1); lit("max_sub",  mk(1, 0, 9'h081, 24'hFFFFFE, C_SUB));
`endif
        step(32'h8000_0000, 1'b1); lit("neg_zero", mk(1, 1, 9'h000, 24'h000000, C_ZERO));
        step(32'h7FC0_0001, 1'b1); lit("qnan",     mk(1, 0, 9'h1C0, 24'hC00001, C_NAN));
        step(32'h0080_0000, 1'b1); lit("min_norm", mk(1, 0, 9'h082, 24'h800000, C_NORM));

        // back-to-back issue, then idle with data held
        step(32'h7F80_0000, 1'b1);
        step(32'hC049_0FDB, 1'b1);
        step(32'h8000_0001, 1'b1);
        step(32'h1234_5678, 1'b0);
`ifdef TORECFN_DAZ_EN
        lit("hold", mk(0, 1, 9'h000, 24'h000000, C_SUB));
`else
        lit("hold", mk(0, 1, 9'h06B, 24'h800000, C_SUB));
`endif
        step(32'h1234_5678, 1'b0);

        step(32'hFFC0_0000, 1'b1);
        step(32'h7F80_0001, 1'b1);
        step(32'h0001_2345, 1'b1);
        step(32'hC049_0FDB, 1'b1);
        lit("pi_neg", mk(1, 1, 9'h101, 24'hC90FDB, C_NORM));
        step(32'h0000_0003, 1'b1);
        step(32'h0000_7FFF, 1'b1);

        // reset on the same edge as a valid operand
        rst = 1'b1;
        step(32'h3F80_0000, 1'b1);
        lit("rst_with_valid", '0);
        rst = 1'b0;
        step(32'h3F80_0000, 1'b0);
        lit("idle_after_rst", '0);

        step(32'h4000_0000, 1'b1);
        step(32'h4000_0000, 1'b0);
        step(32'h0, 1'b0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
